// File: rtl/probe_buffer_pkg.sv
// Shared types and constants for the probe buffer source and sink.
//   probe_word_t       : 64-bit word carried between host and core
//   PROBE_EMPTY_VALUE  : default word returned when a read finds no data
//   PROBE_UF_W         : width of the saturating underflow counter
package probe_buffer_pkg;

   typedef logic [63:0] probe_word_t;

   localparam probe_word_t PROBE_EMPTY_VALUE = 64'h0;
   localparam int          PROBE_UF_W        = 16;

endpackage

// File: rtl/probe_fifo_mem.sv
// Simple dual-port register array backing the probe buffer FIFO.
// Ports:
//   clock         : write clock
//   wen/waddr/wdata : synchronous write port
//   raddr/rdata   : asynchronous read port
// Contents are intentionally not reset.
module probe_fifo_mem
   import probe_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          wen,
   input  logic [AW-1:0] waddr,
   input  probe_word_t   wdata,
   input  logic [AW-1:0] raddr,
   output probe_word_t   rdata
);

   probe_word_t mem [DEPTH];

   always_ff @(posedge clock) begin
      if (wen) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/probe_buffer_source.sv
// Host-to-core probe buffer: the host pushes 64-bit words over a
// valid/ready stream, the core pops them one per asserted ren cycle.
// Ports:
//   clock, reset          : single clock, synchronous active-high reset
//   in_valid/in_ready/in_data : host push stream (in_ready = not full)
//   ren                   : core read strobe, pops one word per cycle
//   read/read_valid       : registered read data and "real word" flag
//   flush                 : discard all queued words
//   count                 : registered occupancy
//   underflow_count       : saturating count of reads while empty
module probe_buffer_source
   import probe_buffer_pkg::*;
#(
   parameter int unsigned DEPTH       = 16,
   parameter probe_word_t EMPTY_VALUE = PROBE_EMPTY_VALUE
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  probe_word_t             in_data,
   input  logic                    ren,
   output probe_word_t             read,
   output logic                    read_valid,
   input  logic                    flush,
   output logic [$clog2(DEPTH):0]  count,
   output logic [PROBE_UF_W-1:0]   underflow_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   logic [PW-1:0] head, tail;
   logic [PW-1:0] head_n, tail_n;
   logic          empty, full, push, pop;
   probe_word_t   head_word;

   assign empty    = (head == tail);
   assign full     = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
   assign in_ready = !full;
   assign push     = in_valid && !full && !flush;
   assign pop      = ren && !empty && !flush;

   always_comb begin
      head_n = head;
      tail_n = tail;
      if (flush) begin
         head_n = '0;
         tail_n = '0;
      end else begin
         if (push) tail_n = tail + PW'(1);
         if (pop)  head_n = head + PW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head            <= '0;
         tail            <= '0;
         count           <= '0;
         read            <= EMPTY_VALUE;
         read_valid      <= 1'b0;
         underflow_count <= '0;
      end else begin
         head  <= head_n;
         tail  <= tail_n;
         count <= tail_n - head_n;
         // flush leaves the read register and underflow counter alone
         if (ren && !flush) begin
            if (!empty) begin
               read       <= head_word;
               read_valid <= 1'b1;
            end else begin
               read       <= EMPTY_VALUE;
               read_valid <= 1'b0;
               if (underflow_count != '1)
                  underflow_count <= underflow_count + PROBE_UF_W'(1);
            end
         end
      end
   end

   probe_fifo_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clock (clock),
      .wen   (push && !reset),
      .waddr (tail[AW-1:0]),
      .wdata (in_data),
      .raddr (head[AW-1:0]),
      .rdata (head_word)
   );

endmodule

// File: tb/tb_probe_buffer_source.sv
module tb_probe_buffer_source;
   import probe_buffer_pkg::*;

   localparam int DEPTH = 16;
   localparam logic [63:0] EV = 64'h0;

   logic        clock = 1'b0;
   logic        reset, in_valid, ren, flush;
   logic        in_ready, read_valid;
   logic [63:0] in_data, read;
   logic [4:0]  count;
   logic [15:0] underflow_count;

   int checks = 0;
   int failures = 0;

   // behavioural reference: a plain queue plus the visible read state
   logic [63:0] q[$];
   logic [63:0] m_read = EV;
   logic        m_rv = 1'b0;
   int          m_uf = 0;

   probe_buffer_source #(.DEPTH(DEPTH), .EMPTY_VALUE(EV)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .ren(ren), .read(read), .read_valid(read_valid),
      .flush(flush), .count(count), .underflow_count(underflow_count)
   );

   always #5 clock = ~clock;

   // apply one clock with the current inputs, updating the model first
   task automatic step();
      bit was_full;
      was_full = (q.size() == DEPTH);
      if (reset) begin
         q.delete();
         m_read = EV; m_rv = 1'b0; m_uf = 0;
      end else if (flush) begin
         q.delete();
      end else begin
         if (ren) begin
            if (q.size() > 0) begin
               m_read = q.pop_front(); m_rv = 1'b1;
            end else begin
               m_read = EV; m_rv = 1'b0;
               if (m_uf < 65535) m_uf++;
            end
         end
         if (in_valid && !was_full) q.push_back(in_data);
      end
      @(posedge clock); #1;
   endtask

   task automatic test_reset();
      reset = 1; in_valid = 0; ren = 0; flush = 0; in_data = '0;
      step();
      reset = 0;
      checks++; if (read !== 64'h0) begin failures++; $display("FAIL reset_read got=%h exp=0", read); end
      checks++; if (read_valid !== 1'b0) begin failures++; $display("FAIL reset_rv got=%b exp=0", read_valid); end
      checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (underflow_count !== 16'd0) begin failures++; $display("FAIL reset_uf got=%0d exp=0", underflow_count); end
   endtask

   task automatic test_underflow();
      ren = 1; step(); ren = 0;
      checks++; if (read !== 64'h0) begin failures++; $display("FAIL uf_read got=%h exp=0", read); end
      checks++; if (read_valid !== 1'b0) begin failures++; $display("FAIL uf_rv got=%b exp=0", read_valid); end
      checks++; if (underflow_count !== 16'd1) begin failures++; $display("FAIL uf_count got=%0d exp=1", underflow_count); end
   endtask

   task automatic test_basic();
      logic [63:0] vals [3];
      vals[0] = 64'h1111; vals[1] = 64'h2222; vals[2] = 64'h3333;
      for (int i = 0; i < 3; i++) begin in_valid = 1; in_data = vals[i]; step(); end
      in_valid = 0;
      checks++; if (count !== 5'd3) begin failures++; $display("FAIL basic_count3 got=%0d exp=3", count); end
      for (int i = 0; i < 3; i++) begin
         ren = 1; step();
         checks++; if (read !== vals[i] || read_valid !== 1'b1) begin
            failures++; $display("FAIL basic_read%0d got=%h/%b exp=%h/1", i, read, read_valid, vals[i]);
         end
      end
      ren = 0;
      checks++; if (count !== 5'd0) begin failures++; $display("FAIL basic_count0 got=%0d exp=0", count); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < DEPTH; i++) begin in_valid = 1; in_data = 64'(i); step(); end
      checks++; if (count !== 5'd16 || in_ready !== 1'b0) begin
         failures++; $display("FAIL fill_full got=%0d/%b exp=16/0", count, in_ready);
      end
      in_data = 64'h99; step();
      checks++; if (count !== 5'd16) begin failures++; $display("FAIL fill_holdoff got=%0d exp=16", count); end
      ren = 1; step(); ren = 0;
      checks++; if (read !== 64'h0 || read_valid !== 1'b1) begin
         failures++; $display("FAIL fill_pop0 got=%h/%b exp=0/1", read, read_valid);
      end
      checks++; if (in_ready !== 1'b1 || count !== 5'd15) begin
         failures++; $display("FAIL fill_freed got=%b/%0d exp=1/15", in_ready, count);
      end
      step(); in_valid = 0;
      checks++; if (count !== 5'd16) begin failures++; $display("FAIL fill_17th got=%0d exp=16", count); end
      for (int i = 1; i <= DEPTH; i++) begin
         ren = 1; step();
         checks++; if (read !== ((i == DEPTH) ? 64'h99 : 64'(i))) begin
            failures++; $display("FAIL fill_drain%0d got=%h exp=%h", i, read, (i == DEPTH) ? 64'h99 : 64'(i));
         end
      end
      ren = 0;
   endtask

   task automatic test_wrap();
      logic [63:0] w [41];
      for (int k = 0; k < 41; k++) w[k] = {$urandom, $urandom};
      in_valid = 1; in_data = w[0]; step();
      for (int k = 0; k < 40; k++) begin
         in_data = w[k+1]; ren = 1; step();
         checks++; if (read !== w[k] || read_valid !== 1'b1 || count !== 5'd1) begin
            failures++; $display("FAIL wrap%0d got=%h/%b/%0d exp=%h/1/1", k, read, read_valid, count, w[k]);
         end
      end
      in_valid = 0; step(); ren = 0;
      checks++; if (read !== w[40] || count !== 5'd0) begin
         failures++; $display("FAIL wrap_last got=%h/%0d exp=%h/0", read, count, w[40]);
      end
   endtask

   task automatic test_simul_empty();
      int uf0;
      logic [63:0] v;
      uf0 = m_uf; v = {$urandom, $urandom};
      in_valid = 1; in_data = v; ren = 1; step(); in_valid = 0;
      checks++; if (read_valid !== 1'b0 || underflow_count !== 16'(uf0 + 1) || count !== 5'd1) begin
         failures++; $display("FAIL simul_empty got=%b/%0d/%0d exp=0/%0d/1", read_valid, underflow_count, count, uf0 + 1);
      end
      step(); ren = 0;
      checks++; if (read !== v || read_valid !== 1'b1) begin
         failures++; $display("FAIL simul_next got=%h/%b exp=%h/1", read, read_valid, v);
      end
   endtask

   task automatic test_flush();
      logic [63:0] r0;
      int uf0;
      for (int i = 0; i < 5; i++) begin in_valid = 1; in_data = 64'hF0 + 64'(i); step(); end
      in_valid = 0;
      r0 = m_read; uf0 = m_uf;
      flush = 1; ren = 1; step(); flush = 0;
      checks++; if (count !== 5'd0 || read !== r0) begin
         failures++; $display("FAIL flush got=%0d/%h exp=0/%h", count, read, r0);
      end
      step(); ren = 0;
      checks++; if (read_valid !== 1'b0 || underflow_count !== 16'(uf0 + 1)) begin
         failures++; $display("FAIL flush_uf got=%b/%0d exp=0/%0d", read_valid, underflow_count, uf0 + 1);
      end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 4; i++) begin in_valid = 1; in_data = {$urandom, $urandom}; step(); end
      ren = 1; step();
      reset = 1; step(); reset = 0; in_valid = 0; ren = 0;
      checks++; if (read !== 64'h0 || read_valid !== 1'b0 || count !== 5'd0 || in_ready !== 1'b1 || underflow_count !== 16'd0) begin
         failures++; $display("FAIL mid_reset got=%h/%b/%0d/%b/%0d exp=0/0/0/1/0", read, read_valid, count, in_ready, underflow_count);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         in_valid = ($urandom_range(0, 9) < 6);
         ren      = ($urandom_range(0, 1) == 1);
         flush    = ($urandom_range(0, 31) == 0);
         in_data  = {$urandom, $urandom};
         step();
         checks++;
         if (read !== m_read || read_valid !== m_rv || count !== 5'(q.size()) ||
             in_ready !== (q.size() < DEPTH) || underflow_count !== 16'(m_uf)) begin
            failures++;
            $display("FAIL random%0d got=%h/%b/%0d/%b/%0d exp=%h/%b/%0d/%b/%0d", c,
                     read, read_valid, count, in_ready, underflow_count,
                     m_read, m_rv, q.size(), q.size() < DEPTH, m_uf);
         end
      end
      in_valid = 0; ren = 0; flush = 0;
   endtask

   initial begin
      test_reset();
      test_underflow();
      test_basic();
      test_fill();
      test_wrap();
      test_simul_empty();
      test_flush();
      test_mid_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/probe_buffer_source.md
# probe_buffer_source

Host-to-core counterpart of the probe buffer sink. The simulation host or a testbench harness pushes 64-bit words into an in-order FIFO over a valid/ready stream. The core under test pops those words through the probe buffer's `read`/read-enable port. The block is synthesizable, so fuzzing stimulus (seeds, tokens, expected values) can be fed to software running on the core without DPI calls on the read path.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `EMPTY_VALUE`, 64'h0: word returned on a read from an empty buffer.
- `clock` input 1: single clock; all state updates on posedge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: host word valid.
- `in_ready` output 1: buffer can accept a word (not full).
- `in_data` input 64: host word.
- `ren` input 1: core read strobe; pops one word per asserted cycle.
- `read` output 64: registered read data.
- `read_valid` output 1: `read` holds a real popped word, not `EMPTY_VALUE`.
- `flush` input 1: discard all queued words.
- `count` output $clog2(DEPTH)+1: current occupancy.
- `underflow_count` output 16: saturating count of reads issued while empty.

## Operation
- FIFO storage is `DEPTH` × 64 bits, with head and tail pointers of width $clog2(DEPTH)+1, using the extra wrap bit.
  - Empty: the pointers are equal.
  - Full: the index bits are equal and the wrap bits differ.
  - Pointers wrap naturally at 2·DEPTH.
- Push:
  - `in_ready` = !full.
  - A push occurs when `in_valid && in_ready`.
  - It writes `in_data` at the tail and advances the tail.
- Pop: `ren` while non-empty takes the head word and advances the head.
  - On the next edge, `read` ← the head word and `read_valid` ← 1.
- Empty read: `ren` while empty.
  - On the next edge, `read` ← `EMPTY_VALUE` and `read_valid` ← 0.
  - `underflow_count` increments and saturates at 16'hFFFF.
- With no `ren`, `read` and `read_valid` hold their values.
- Simultaneous push and pop:
  - Non-empty and not full: both occur, `count` is unchanged, and `read` gets the old head.
  - Empty: no bypass. The pop is an underflow and the pushed word is queued.
  - Full: `in_ready` = 0, so only the pop occurs. The freed slot is visible as `in_ready` = 1 on the next cycle.
- `flush`:
  - Sets head and tail to 0 next edge, which gives `count` = 0.
  - Any push or pop in the same cycle is ignored.
  - `read`, `read_valid` and `underflow_count` are untouched.
- `count` = tail − head, computed modulo 2·DEPTH. It is registered and consistent with the pointers every cycle.

## Timing
- Reset values:
  - `in_ready` = 1 (buffer empty).
  - `read` = `EMPTY_VALUE`.
  - `read_valid` = 0.
  - `count` = 0.
  - `underflow_count` = 0.
- Pointers are 0 after reset. Storage contents are not reset.
- Reset asserted mid-operation overrides push, pop and flush in that cycle and discards all queued words.
- Push to readable latency:
  - A word pushed in cycle N can be popped by a `ren` in cycle N+1.
  - `read` shows it in cycle N+2.
- Read latency is 1 cycle: `ren` in cycle N gives `read` and `read_valid` updated in N+1.
- Back-to-back `ren` is allowed every cycle, sustaining one word per cycle.
- `in_ready` is derived from registered pointers only. It has no combinational path from `ren` or `in_valid`.

## Structure
- A shared package `probe_buffer_pkg` holds:
  - the `probe_word_t` 64-bit typedef;
  - the `PROBE_EMPTY_VALUE` default constant;
  - the underflow counter width constant.
- The sink-side module uses the same package.
- One sub-module, `probe_fifo_mem`: a simple dual-port `DEPTH` × 64 register array, with write port (wen, waddr, wdata) and asynchronous read port (raddr, rdata). The top level owns pointers, flags, counters and the read register.

## Test plan
- Reset, then `ren` pulse with `EMPTY_VALUE` = 0:
  - the cycle after reset shows `read` = 0, `read_valid` = 0, `count` = 0, `in_ready` = 1;
  - after the `ren` pulse, `read` = 0, `read_valid` = 0, `underflow_count` = 1.
- Push 0x1111, 0x2222, 0x3333 on consecutive cycles, then `ren` on 3 consecutive cycles:
  - `read` = 0x1111, 0x2222, 0x3333 on the following cycles, with `read_valid` = 1;
  - `count` returns 3 → 0.
- Fill `DEPTH` = 16 with values 0..15:
  - `in_ready` = 0 with `count` = 16, and a 17th `in_valid` is held off;
  - one `ren` gives `read` = 0, and `in_ready` = 1 on the next cycle;
  - the 17th word is accepted and later read last.
- Wrap-around: push and pop continuously for 40 words with a one-entry steady occupancy:
  - the read sequence exactly equals the pushed sequence;
  - `count` stays at 1.
- Push and `ren` in the same cycle on an empty buffer:
  - underflow increments and `read_valid` = 0;
  - the next `ren` returns the pushed word.
- `flush` with 5 queued words while `ren` is asserted:
  - `count` = 0 next cycle and `read` is unchanged;
  - a subsequent `ren` underflows.
- Assert `reset` mid-stream with 4 queued words: all outputs return to their reset values on the next cycle.
